rtc_digit_scanner: RTL and testbench
====================================

# rtc_digit_scanner

Sequences the RTC time/date registers one BCD digit at a time into the digit decoder, which sits directly downstream and consumes `bcd_num` and `enable`. A `load` strobe captures a six-byte BCD snapshot. A `start` strobe then presents the snapshot's 12 digits in a fixed order, holding each digit for a programmable number of cycles. Any nibble greater than 9 is blanked and flagged.

## Interface
- `HOLD_CYCLES`, default 4: cycles each digit is held on the outputs. Legal range 1..255.
- `clk` input 1: system clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: one-cycle strobe; captures `hour`, `min`, `sec`, `day`, `month`, `year`.
- `hour`, `min`, `sec` inputs 8 each: packed BCD, `[7:4]` = tens, `[3:0]` = units.
- `day`, `month`, `year` inputs 8 each: packed BCD, same packing.
- `start` input 1: one-cycle strobe; begins a scan of the captured snapshot.
- `bcd_num` output 4: current digit, driven to the decoder.
- `enable` output 1: high while `bcd_num` holds a valid digit (0..9).
- `digit_idx` output 4: index 0..11 of the digit currently presented.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when a scan completes.
- `bcd_err` output 1: sticky flag; set when any scanned nibble is greater than 9.

## Operation
- Snapshot: a 48-bit register.
  - `load` in IDLE: the register is written on that edge.
  - `load` while busy: the inputs are captured into a 48-bit shadow and a pending flag is set. The snapshot takes the shadow value on the DONE cycle. A newer `load` while busy overwrites the shadow.
- Digit order, by index:
  - 0/1: hour tens/units.
  - 2/3: min tens/units.
  - 4/5: sec tens/units.
  - 6/7: day tens/units.
  - 8/9: month tens/units.
  - 10/11: year tens/units.
- FSM states are IDLE, SCAN and DONE.
  - IDLE → SCAN on `start`.
  - SCAN → DONE when `digit_idx` = 11 and the hold counter = `HOLD_CYCLES`−1.
  - DONE → IDLE unconditionally, after one cycle.
- Hold counter: 8 bits, runs in SCAN. At `HOLD_CYCLES`−1 it clears and `digit_idx` increments; it never wraps past 11.
- Blanking: in SCAN, when the selected nibble is greater than 9:
  - `enable` = 0 and `bcd_num` = 0 for that slot.
  - `bcd_err` is set.
- `bcd_err` clears on any `load` accepted in IDLE, and on the DONE cycle if a pending load is applied. If set and cleared in the same cycle, set wins.
- `start` while `busy` = 1 or in DONE: ignored, with no queueing.
- `load` and `start` in the same IDLE cycle: the scan uses the newly loaded values.
- Outside SCAN: `enable` = 0, `bcd_num` = 0, `digit_idx` = 0.

## Timing
- All outputs are registered.
- Reset values:
  - `bcd_num` = 0, `enable` = 0, `digit_idx` = 0.
  - `busy` = 0, `done` = 0, `bcd_err` = 0.
  - Snapshot, shadow and pending flag = 0; FSM = IDLE.
- Scan sequence, with `start` sampled at edge 0:
  - `busy` = 1 from cycle 1.
  - Digit k is presented in cycles 1+k·H through (k+1)·H, where H = `HOLD_CYCLES`.
  - `done` = 1 and `busy` = 0 in cycle 12·H+1.
  - A new `start` is accepted from cycle 12·H+2.
- H = 1 gives one digit per cycle, with no gaps between digits.
- Reset asserted mid-scan: all outputs go to reset values immediately (asynchronous), with no `done`. The snapshot is lost.
- Reset deassertion is synchronised externally. The block acts on the first rising edge after deassertion.

## Test plan
- **Reset check:** reset low mid-scan → all outputs 0 immediately; `start` after release → scan begins at digit 0.
- **Basic scan:** H = 4, load hour = 8'h23, min = 8'h59, sec = 8'h07, day = 8'h31, month = 8'h12, year = 8'h16, then `start`.
  - `bcd_num` sequence is 2,3,5,9,0,7,3,1,1,2,1,6.
  - Each digit is held 4 cycles with `enable` = 1.
  - `done` pulses at cycle 49; `bcd_err` = 0.
- **Invalid nibble:** H = 1, min = 8'hA5.
  - Slot 2: `enable` = 0, `bcd_num` = 0, `bcd_err` = 1.
  - Slot 3 presents 5 with `enable` = 1.
  - `bcd_err` remains 1 until the next idle `load`.
- **Start while busy:** `start` re-pulsed at cycles 5 and 20 of an H = 2 scan → ignored; `done` still pulses at cycle 25 only.
- **Load while busy:** `load` with hour = 8'h10 at cycle 3 of a scan.
  - The current scan still shows the old hour digits.
  - The next scan shows 1,0.
- **Same-cycle load and start:** `load` and `start` in the same IDLE cycle → first digit is the new hour tens.

Source files
------------

// File: rtl/rtc_digit_scanner.sv
// Presents a captured six-byte BCD time/date snapshot one digit at a time to the
// downstream digit decoder, blanking and flagging any nibble above 9.
module rtc_digit_scanner #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [7:0] day,
    input  logic [7:0] month,
    input  logic [7:0] year,
    input  logic       start,
    output logic [3:0] bcd_num,
    output logic       enable,
    output logic [3:0] digit_idx,
    output logic       busy,
    output logic       done,
    output logic       bcd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST_IDX  = 4'd11;

    // Snapshot packing: hour in the top byte down to year in the bottom byte.
    function automatic logic [3:0] sel_nibble(input logic [47:0] snap, input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = snap[47:44];
            4'd1:    nib = snap[43:40];
            4'd2:    nib = snap[39:36];
            4'd3:    nib = snap[35:32];
            4'd4:    nib = snap[31:28];
            4'd5:    nib = snap[27:24];
            4'd6:    nib = snap[23:20];
            4'd7:    nib = snap[19:16];
            4'd8:    nib = snap[15:12];
            4'd9:    nib = snap[11:8];
            4'd10:   nib = snap[7:4];
            4'd11:   nib = snap[3:0];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [47:0] snap_q, snap_d;
    logic [47:0] shadow_q, shadow_d;
    logic        pend_q, pend_d;
    logic [3:0]  bcd_num_q, bcd_num_d;
    logic        enable_q, enable_d;
    logic [3:0]  digit_idx_q, digit_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bcd_err_q, bcd_err_d;

    logic [47:0] capture_s;
    logic        err_clr_s;
    logic        err_set_s;
    logic [3:0]  nib_s;
    logic        nib_valid_s;

    assign capture_s = {hour, min, sec, day, month, year};

    // Sequencing: state, digit index, hold counter, snapshot and deferred load.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        err_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    snap_d    = capture_s;
                    err_clr_s = 1'b1;
                end else begin
                    snap_d = snap_q;
                end
                if (start) begin
                    state_d = ST_SCAN;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // A load mid-scan is parked so the digits on display stay coherent.
                if (load) begin
                    shadow_d = capture_s;
                    pend_d   = 1'b1;
                end else begin
                    shadow_d = shadow_q;
                end
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                cnt_d   = 8'd0;
                pend_d  = 1'b0;
                if (pend_q) begin
                    snap_d    = shadow_q;
                    err_clr_s = 1'b1;
                end else begin
                    snap_d = snap_q;
                end
                // A load arriving on this very cycle is newer than anything parked.
                if (load) begin
                    snap_d    = capture_s;
                    err_clr_s = 1'b1;
                end else begin
                    shadow_d = shadow_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                cnt_d   = 8'd0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Next-value of the registered outputs, derived from the next state.
    always_comb begin
        nib_s       = sel_nibble(snap_d, idx_d);
        nib_valid_s = (nib_s <= 4'd9);
        if (state_d == ST_SCAN) begin
            bcd_num_d   = nib_valid_s ? nib_s : 4'd0;
            enable_d    = nib_valid_s;
            digit_idx_d = idx_d;
            err_set_s   = ~nib_valid_s;
        end else begin
            bcd_num_d   = 4'd0;
            enable_d    = 1'b0;
            digit_idx_d = 4'd0;
            err_set_s   = 1'b0;
        end
        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
        if (err_set_s) begin
            bcd_err_d = 1'b1;
        end else if (err_clr_s) begin
            bcd_err_d = 1'b0;
        end else begin
            bcd_err_d = bcd_err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 8'd0;
            snap_q      <= 48'd0;
            shadow_q    <= 48'd0;
            pend_q      <= 1'b0;
            bcd_num_q   <= 4'd0;
            enable_q    <= 1'b0;
            digit_idx_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            bcd_num_q   <= bcd_num_d;
            enable_q    <= enable_d;
            digit_idx_q <= digit_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

    assign bcd_num   = bcd_num_q;
    assign enable    = enable_q;
    assign digit_idx = digit_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_rtc_digit_scanner.sv
// Scoreboard bench for rtc_digit_scanner: three instances with hold lengths 4, 1 and 2.
module tb_rtc_digit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       load_s  [3];
    logic       start_s [3];
    logic [7:0] hour_s  [3];
    logic [7:0] min_s   [3];
    logic [7:0] sec_s   [3];
    logic [7:0] day_s   [3];
    logic [7:0] month_s [3];
    logic [7:0] year_s  [3];
    logic [3:0] bcd_num_s   [3];
    logic       enable_s    [3];
    logic [3:0] digit_idx_s [3];
    logic       busy_s      [3];
    logic       done_s      [3];
    logic       bcd_err_s   [3];

    rtc_digit_scanner #(.HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .reset(reset), .load(load_s[0]),
        .hour(hour_s[0]), .min(min_s[0]), .sec(sec_s[0]),
        .day(day_s[0]), .month(month_s[0]), .year(year_s[0]),
        .start(start_s[0]), .bcd_num(bcd_num_s[0]), .enable(enable_s[0]),
        .digit_idx(digit_idx_s[0]), .busy(busy_s[0]), .done(done_s[0]), .bcd_err(bcd_err_s[0])
    );
    rtc_digit_scanner #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .reset(reset), .load(load_s[1]),
        .hour(hour_s[1]), .min(min_s[1]), .sec(sec_s[1]),
        .day(day_s[1]), .month(month_s[1]), .year(year_s[1]),
        .start(start_s[1]), .bcd_num(bcd_num_s[1]), .enable(enable_s[1]),
        .digit_idx(digit_idx_s[1]), .busy(busy_s[1]), .done(done_s[1]), .bcd_err(bcd_err_s[1])
    );
    rtc_digit_scanner #(.HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .reset(reset), .load(load_s[2]),
        .hour(hour_s[2]), .min(min_s[2]), .sec(sec_s[2]),
        .day(day_s[2]), .month(month_s[2]), .year(year_s[2]),
        .start(start_s[2]), .bcd_num(bcd_num_s[2]), .enable(enable_s[2]),
        .digit_idx(digit_idx_s[2]), .busy(busy_s[2]), .done(done_s[2]), .bcd_err(bcd_err_s[2])
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [11:0] sb [$];
    logic        model_err [3];

    function automatic int hold_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [47:0] snap_of(input int d);
        return {hour_s[d], min_s[d], sec_s[d], day_s[d], month_s[d], year_s[d]};
    endfunction

    // Observed word: {bcd_num, enable, digit_idx, busy, done, bcd_err}
    function automatic logic [11:0] obs(input int d);
        return {bcd_num_s[d], enable_s[d], digit_idx_s[d], busy_s[d], done_s[d], bcd_err_s[d]};
    endfunction

    task automatic compare(input string tag, input logic [11:0] got, input logic [11:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Expected cycle-by-cycle output of a full scan, starting with cycle 1.
    task automatic push_scan(input int d, input logic [47:0] snap);
        int   h;
        logic e;
        h = hold_of(d);
        e = model_err[d];
        for (int k = 0; k < 12; k++) begin
            logic [47:0] t;
            logic [3:0]  nib;
            logic        v;
            t   = snap >> (44 - 4 * k);
            nib = t[3:0];
            v   = (nib < 4'd10);
            if (!v) e = 1'b1;
            for (int r = 0; r < h; r++)
                sb.push_back({v ? nib : 4'd0, v, 4'(k), 1'b1, 1'b0, e});
        end
        sb.push_back({4'd0, 1'b0, 4'd0, 1'b0, 1'b1, e});
        model_err[d] = e;
    endtask

    task automatic run_check(input int d, input int n, input string tag,
                             input int s1, input int s2, input int ldc, input logic [7:0] ldh);
        logic [11:0] want;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            want = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
            compare($sformatf("%s_c%0d", tag, c), obs(d), want);
            start_s[d] = (c == s1) || (c == s2);
            load_s[d]  = (c == ldc);
            if (c == ldc) hour_s[d] = ldh;
        end
    endtask

    task automatic check_idle(input int d, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            compare(tag, obs(d), {11'd0, model_err[d]});
        end
    endtask

    task automatic set_inputs(input int d, input logic [47:0] v);
        {hour_s[d], min_s[d], sec_s[d], day_s[d], month_s[d], year_s[d]} = v;
    endtask

    task automatic do_load(input int d, input logic [47:0] v);
        @(negedge clk);
        set_inputs(d, v);
        load_s[d] = 1'b1;
        @(posedge clk);
        #1 load_s[d] = 1'b0;
        model_err[d] = 1'b0;
    endtask

    task automatic do_start(input int d, input logic [47:0] snap);
        @(negedge clk);
        start_s[d] = 1'b1;
        push_scan(d, snap);
        @(posedge clk);
        #1 start_s[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            load_s[d] = 1'b0; start_s[d] = 1'b0; model_err[d] = 1'b0;
            set_inputs(d, 48'd0);
        end
        #12;
        for (int d = 0; d < 3; d++) compare($sformatf("reset_val_%0d", d), obs(d), 12'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) check_idle(d, 1, "idle_after_reset");

        // Basic scan, H=4
        do_load(0, {8'h23, 8'h59, 8'h07, 8'h31, 8'h12, 8'h16});
        check_idle(0, 1, "basic_pre");
        do_start(0, snap_of(0));
        run_check(0, 49, "basic", 0, 0, 0, 8'h00);
        check_idle(0, 2, "basic_post");

        // Invalid nibble, H=1
        do_load(1, {8'h12, 8'hA5, 8'h34, 8'h01, 8'h02, 8'h99});
        do_start(1, snap_of(1));
        run_check(1, 13, "badnib", 0, 0, 0, 8'h00);
        check_idle(1, 3, "badnib_sticky");
        do_load(1, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        check_idle(1, 2, "badnib_cleared");

        // Start while busy, H=2
        do_load(2, {8'h08, 8'h17, 8'h26, 8'h35, 8'h04, 8'h53});
        do_start(2, snap_of(2));
        run_check(2, 25, "start_busy", 5, 20, 0, 8'h00);
        check_idle(2, 3, "start_busy_post");

        // Load while busy, H=2: current scan keeps old hour, next shows 1,0
        do_start(2, snap_of(2));
        run_check(2, 25, "load_busy_old", 0, 0, 3, 8'h10);
        check_idle(2, 2, "load_busy_mid");
        do_start(2, snap_of(2));
        run_check(2, 25, "load_busy_new", 0, 0, 0, 8'h00);

        // Same-cycle load and start, H=1
        @(negedge clk);
        set_inputs(1, {8'h87, 8'h65, 8'h43, 8'h21, 8'h09, 8'h88});
        load_s[1]    = 1'b1;
        start_s[1]   = 1'b1;
        model_err[1] = 1'b0;
        push_scan(1, snap_of(1));
        @(posedge clk);
        #1 begin load_s[1] = 1'b0; start_s[1] = 1'b0; end
        run_check(1, 13, "load_start", 0, 0, 0, 8'h00);

        // Reset mid-scan, H=4: outputs drop immediately, snapshot lost
        do_start(0, snap_of(0));
        run_check(0, 10, "pre_reset", 0, 0, 0, 8'h00);
        sb.delete();
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            model_err[d] = 1'b0;
            compare($sformatf("reset_mid_%0d", d), obs(d), 12'd0);
        end
        @(negedge clk);
        compare("reset_hold", obs(0), 12'd0);
        reset = 1'b1;
        do_start(0, 48'd0);
        run_check(0, 49, "post_reset", 0, 0, 0, 8'h00);
        check_idle(0, 1, "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
